// File: rtl/ras_checkpoint_predictor.sv
// Return-address stack with a circular queue of speculative checkpoints.
// Each checkpoint snapshots {ptr, count, top value}, and a mispredict restores one of them.

package cvw;
    typedef struct packed {
        int unsigned XLEN;
    } cvw_t;

    localparam cvw_t CVW_DEFAULT = '{XLEN: 32};
endpackage

module ras_checkpoint_predictor #(
    parameter cvw::cvw_t P          = cvw::CVW_DEFAULT,
    parameter int        STACK_SIZE = 16,
    parameter int        CKPT_NUM   = 4,
    parameter bit        OVF_WRAP   = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          push_i,
    input  logic [P.XLEN-1:0]             push_addr_i,
    input  logic                          pop_i,
    input  logic                          ckpt_alloc_i,
    input  logic                          ckpt_release_i,
    input  logic                          ckpt_restore_i,
    input  logic [$clog2(CKPT_NUM)-1:0]   ckpt_restore_id_i,
    output logic [P.XLEN-1:0]             top_o,
    output logic                          top_valid_o,
    output logic [$clog2(STACK_SIZE):0]   count_o,
    output logic                          full_o,
    output logic [$clog2(CKPT_NUM)-1:0]   ckpt_id_o,
    output logic                          ckpt_full_o,
    output logic                          ckpt_empty_o
);
    localparam int XLEN = P.XLEN;
    localparam int PW   = $clog2(STACK_SIZE);
    localparam int CW   = PW + 1;
    localparam int IW   = $clog2(CKPT_NUM);
    localparam int UW   = IW + 1;
    localparam logic [CW-1:0] STACK_MAX = CW'(STACK_SIZE);
    localparam logic [UW-1:0] CKPT_MAX  = UW'(CKPT_NUM);

    logic [PW-1:0]   ptr, nextPtr;
    logic [CW-1:0]   count, nextCount;
    logic [XLEN-1:0] mem [STACK_SIZE];

    logic [IW-1:0]   head, tail, nextHead, nextTail;
    logic [UW-1:0]   used, nextUsed;
    logic [PW-1:0]   ckPtr   [CKPT_NUM];
    logic [CW-1:0]   ckCount [CKPT_NUM];
    logic [XLEN-1:0] ckTop   [CKPT_NUM];

    logic            memWe;
    logic [PW-1:0]   memIdx;
    logic [XLEN-1:0] memData;
    logic [XLEN-1:0] nextTop;
    logic            releaseOk;
    logic            allocOk;
    logic [IW-1:0]   keepSpan;

    // Stack next state; a restore overrides every stack operation in the same cycle.
    always_comb begin
        nextPtr   = ptr;
        nextCount = count;
        memWe     = 1'b0;
        memIdx    = ptr;
        memData   = push_addr_i;
        if (ckpt_restore_i) begin
            nextPtr   = ckPtr[ckpt_restore_id_i];
            nextCount = ckCount[ckpt_restore_id_i];
            memWe     = 1'b1;
            memIdx    = ckPtr[ckpt_restore_id_i];
            memData   = ckTop[ckpt_restore_id_i];
        end else if (push_i && pop_i && count != '0) begin
            memWe = 1'b1;
        end else if (push_i && !(count == STACK_MAX && !OVF_WRAP)) begin
            nextPtr = ptr + PW'(1);
            memWe   = 1'b1;
            memIdx  = ptr + PW'(1);
            if (count != STACK_MAX) begin
                nextCount = count + CW'(1);
            end
        end else if (pop_i && !push_i && count != '0) begin
            nextPtr   = ptr - PW'(1);
            nextCount = count - CW'(1);
        end
        nextTop = memWe ? memData : mem[nextPtr];
    end

    // Checkpoint queue next state; a same-cycle release retires the head before anything else.
    always_comb begin
        releaseOk = ckpt_release_i && used != '0;
        allocOk   = ckpt_alloc_i && !ckpt_restore_i && (used != CKPT_MAX || ckpt_release_i);
        nextHead  = releaseOk ? head + IW'(1) : head;
        nextTail  = tail;
        keepSpan  = ckpt_restore_id_i - nextHead;
        nextUsed  = used + UW'(allocOk) - UW'(releaseOk);
        if (ckpt_restore_i) begin
            nextTail = ckpt_restore_id_i + IW'(1);
            nextUsed = {1'b0, keepSpan} + UW'(1);
        end else if (allocOk) begin
            nextTail = tail + IW'(1);
        end
    end

    // All architectural state, cleared asynchronously so no speculation survives a reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr   <= '0;
            count <= '0;
            head  <= '0;
            tail  <= '0;
            used  <= '0;
            for (int i = 0; i < STACK_SIZE; i++) begin
                mem[i] <= '0;
            end
            for (int i = 0; i < CKPT_NUM; i++) begin
                ckPtr[i]   <= '0;
                ckCount[i] <= '0;
                ckTop[i]   <= '0;
            end
        end else begin
            ptr   <= nextPtr;
            count <= nextCount;
            head  <= nextHead;
            tail  <= nextTail;
            used  <= nextUsed;
            if (memWe) begin
                mem[memIdx] <= memData;
            end
            if (allocOk) begin
                ckPtr[tail]   <= nextPtr;
                ckCount[tail] <= nextCount;
                ckTop[tail]   <= nextTop;
            end
        end
    end

    assign top_o        = mem[ptr];
    assign top_valid_o  = count != '0;
    assign count_o      = count;
    assign full_o       = count == STACK_MAX;
    assign ckpt_id_o    = tail;
    assign ckpt_full_o  = used == CKPT_MAX;
    assign ckpt_empty_o = used == '0;

    restoreNotReleased: assert property (@(posedge clk) disable iff (!reset_n)
        !(ckpt_restore_i && ckpt_release_i && used != '0 && ckpt_restore_id_i == head));

endmodule

// File: tb/tb_ras_checkpoint_predictor.sv
// Self-checking bench: two predictors (overflow wrap and overflow drop) share stimulus
// and are compared every cycle against a queue-based model of the stack and checkpoints.

module tb_ras_checkpoint_predictor;
    localparam int SS = 4;
    localparam int CK = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        push, pop, alloc, rel, restore;
    logic [31:0] addr;
    logic [0:0]  rid;

    logic [31:0] topOut     [2];
    logic        validOut   [2];
    logic [2:0]  countOut   [2];
    logic        fullOut    [2];
    logic [0:0]  idOut      [2];
    logic        ckFullOut  [2];
    logic        ckEmptyOut [2];

    always #5 clk = ~clk;

    ras_checkpoint_predictor #(.STACK_SIZE(SS), .CKPT_NUM(CK), .OVF_WRAP(1'b1)) dutWrap (
        .clk(clk), .reset_n(reset_n), .push_i(push), .push_addr_i(addr), .pop_i(pop),
        .ckpt_alloc_i(alloc), .ckpt_release_i(rel), .ckpt_restore_i(restore),
        .ckpt_restore_id_i(rid), .top_o(topOut[0]), .top_valid_o(validOut[0]),
        .count_o(countOut[0]), .full_o(fullOut[0]), .ckpt_id_o(idOut[0]),
        .ckpt_full_o(ckFullOut[0]), .ckpt_empty_o(ckEmptyOut[0])
    );

    ras_checkpoint_predictor #(.STACK_SIZE(SS), .CKPT_NUM(CK), .OVF_WRAP(1'b0)) dutDrop (
        .clk(clk), .reset_n(reset_n), .push_i(push), .push_addr_i(addr), .pop_i(pop),
        .ckpt_alloc_i(alloc), .ckpt_release_i(rel), .ckpt_restore_i(restore),
        .ckpt_restore_id_i(rid), .top_o(topOut[1]), .top_valid_o(validOut[1]),
        .count_o(countOut[1]), .full_o(fullOut[1]), .ckpt_id_o(idOut[1]),
        .ckpt_full_o(ckFullOut[1]), .ckpt_empty_o(ckEmptyOut[1])
    );

    typedef struct packed {
        logic [31:0] top;
        logic [2:0]  count;
        logic [1:0]  ptr;
    } snap_t;

    typedef struct packed {
        logic [0:0]      id;
        snap_t [1:0]     s;
    } ckpt_t;

    logic [31:0] mMem [2][SS];
    int          mPtr   [2];
    int          mCount [2];
    ckpt_t       ckq [$];
    int          nextId;
    int          compared   = 0;
    int          mismatched = 0;
    bit          checkEn    = 1'b0;

    function automatic logic [31:0] mTop(input int m);
        return mMem[m][mPtr[m]];
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic modelReset();
        for (int m = 0; m < 2; m++) begin
            mPtr[m]   = 0;
            mCount[m] = 0;
            for (int i = 0; i < SS; i++) mMem[m][i] = '0;
        end
        ckq.delete();
        nextId = 0;
    endtask

    task automatic stackStep(input int m, input bit wrap);
        if (push && pop && mCount[m] != 0) begin
            mMem[m][mPtr[m]] = addr;
        end else if (push) begin
            if (!(mCount[m] == SS && !wrap)) begin
                mPtr[m] = (mPtr[m] + 1) % SS;
                mMem[m][mPtr[m]] = addr;
                if (mCount[m] < SS) mCount[m]++;
            end
        end else if (pop && mCount[m] != 0) begin
            mPtr[m] = (mPtr[m] + SS - 1) % SS;
            mCount[m]--;
        end
    endtask

    task automatic modelStep();
        bit    doRelease;
        bit    doAlloc;
        int    k;
        ckpt_t entry;
        doRelease = rel && ckq.size() != 0;
        doAlloc   = alloc && !restore && (ckq.size() < CK || rel);
        if (doRelease) void'(ckq.pop_front());
        if (restore) begin
            k = -1;
            for (int i = 0; i < ckq.size(); i++) begin
                if (ckq[i].id == rid) k = i;
            end
            if (k < 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL restore_target: got no live checkpoint, expected id %0d live", rid);
            end else begin
                for (int m = 0; m < 2; m++) begin
                    mPtr[m]   = int'(ckq[k].s[m].ptr);
                    mCount[m] = int'(ckq[k].s[m].count);
                    mMem[m][mPtr[m]] = ckq[k].s[m].top;
                end
                while (ckq.size() > k + 1) void'(ckq.pop_back());
            end
            nextId = (int'(rid) + 1) % CK;
        end else begin
            stackStep(0, 1'b1);
            stackStep(1, 1'b0);
            if (doAlloc) begin
                entry.id = 1'(nextId);
                for (int m = 0; m < 2; m++) begin
                    entry.s[m].top   = mTop(m);
                    entry.s[m].count = 3'(mCount[m]);
                    entry.s[m].ptr   = 2'(mPtr[m]);
                end
                ckq.push_back(entry);
                nextId = (nextId + 1) % CK;
            end
        end
    endtask

    task automatic compareAll();
        for (int m = 0; m < 2; m++) begin
            checkOutput($sformatf("top%0d", m), 64'(topOut[m]), 64'(mTop(m)));
            checkOutput($sformatf("valid%0d", m), 64'(validOut[m]), 64'(mCount[m] != 0));
            checkOutput($sformatf("count%0d", m), 64'(countOut[m]), 64'(mCount[m]));
            checkOutput($sformatf("full%0d", m), 64'(fullOut[m]), 64'(mCount[m] == SS));
            checkOutput($sformatf("ckptId%0d", m), 64'(idOut[m]), 64'(nextId));
            checkOutput($sformatf("ckptFull%0d", m), 64'(ckFullOut[m]), 64'(ckq.size() == CK));
            checkOutput($sformatf("ckptEmpty%0d", m), 64'(ckEmptyOut[m]), 64'(ckq.size() == 0));
        end
    endtask

    task automatic checkReset(input string tag);
        for (int m = 0; m < 2; m++) begin
            checkOutput($sformatf("%s_top%0d", tag, m), 64'(topOut[m]), 64'(0));
            checkOutput($sformatf("%s_valid%0d", tag, m), 64'(validOut[m]), 64'(0));
            checkOutput($sformatf("%s_count%0d", tag, m), 64'(countOut[m]), 64'(0));
            checkOutput($sformatf("%s_full%0d", tag, m), 64'(fullOut[m]), 64'(0));
            checkOutput($sformatf("%s_ckptId%0d", tag, m), 64'(idOut[m]), 64'(0));
            checkOutput($sformatf("%s_ckptFull%0d", tag, m), 64'(ckFullOut[m]), 64'(0));
            checkOutput($sformatf("%s_ckptEmpty%0d", tag, m), 64'(ckEmptyOut[m]), 64'(1));
        end
    endtask

    // Drives one cycle of inputs at the falling edge and advances the model at the rising edge.
    task automatic applyStimulus(input bit pu, input logic [31:0] a, input bit po, input bit al,
                                 input bit re, input bit rs, input logic [0:0] id);
        @(negedge clk);
        push    = pu;
        addr    = a;
        pop     = po;
        alloc   = al;
        rel     = re;
        restore = rs;
        rid     = id;
        @(posedge clk);
        modelStep();
    endtask

    always @(negedge clk) begin
        if (checkEn && reset_n) compareAll();
    end

    initial begin
        int          lo;
        int          k;
        int          wrapTops [4];
        int          dropTops [4];
        bit          pu, po, al, re, rs;
        logic [0:0]  id;
        wrapTops = '{5, 4, 3, 2};
        dropTops = '{4, 3, 2, 1};

        reset_n = 1'b1;
        {push, pop, alloc, rel, restore} = '0;
        addr = '0;
        rid  = '0;
        #2 reset_n = 1'b0;
        modelReset();
        #2 checkReset("initReset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        checkEn = 1'b1;

        // Push A,B,C then pop them back in reverse order
        applyStimulus(1, 32'hA, 0, 0, 0, 0, 0);
        applyStimulus(1, 32'hB, 0, 0, 0, 0, 0);
        applyStimulus(1, 32'hC, 0, 0, 0, 0, 0);
        checkOutput("lifo_topC", 64'(mTop(0)), 64'hC);
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        checkOutput("lifo_topB", 64'(mTop(0)), 64'hB);
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        checkOutput("lifo_topA", 64'(mTop(0)), 64'hA);
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        checkOutput("lifo_emptyCount", 64'(mCount[0]), 64'(0));
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        checkOutput("lifo_underflowCount", 64'(mCount[1]), 64'(0));

        // Overflow: wrap keeps the newest four, drop keeps the oldest four
        for (int i = 1; i <= 5; i++) applyStimulus(1, 32'(i), 0, 0, 0, 0, 0);
        checkOutput("ovf_countWrap", 64'(mCount[0]), 64'(4));
        checkOutput("ovf_countDrop", 64'(mCount[1]), 64'(4));
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("ovf_wrapPop%0d", i), 64'(mTop(0)), 64'(wrapTops[i]));
            checkOutput($sformatf("ovf_dropPop%0d", i), 64'(mTop(1)), 64'(dropTops[i]));
            applyStimulus(0, 0, 1, 0, 0, 0, 0);
        end

        // Checkpoint then mispredict restores the pre-speculation top
        applyStimulus(1, 32'hA0, 0, 0, 0, 0, 0);
        checkOutput("ckpt_firstId", 64'(nextId), 64'(0));
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        applyStimulus(1, 32'hBAD, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        checkOutput("restore_top", 64'(mTop(0)), 64'hA0);
        checkOutput("restore_count", 64'(mCount[0]), 64'(1));
        checkOutput("restore_ckptId", 64'(nextId), 64'(1));
        applyStimulus(0, 0, 0, 0, 1, 0, 0);

        // Checkpoint queue full, ignored alloc, alloc together with release
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        checkOutput("ckq_fullSize", 64'(ckq.size()), 64'(2));
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        checkOutput("ckq_ignoredId", 64'(nextId), 64'(1));
        applyStimulus(0, 0, 0, 1, 1, 0, 0);
        checkOutput("ckq_allocRelSize", 64'(ckq.size()), 64'(2));
        checkOutput("ckq_allocRelId", 64'(nextId), 64'(0));
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);

        // Replace on count 1, then restore wins over a same-cycle push
        applyStimulus(1, 32'hAA, 1, 0, 0, 0, 0);
        checkOutput("replace_top", 64'(mTop(0)), 64'hAA);
        checkOutput("replace_count", 64'(mCount[0]), 64'(1));
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        applyStimulus(1, 32'hBB, 0, 0, 0, 1, 0);
        checkOutput("restorePush_top", 64'(mTop(0)), 64'hAA);
        checkOutput("restorePush_count", 64'(mCount[0]), 64'(1));
        applyStimulus(0, 0, 0, 0, 1, 0, 0);

        // Asynchronous reset in the middle of speculation
        applyStimulus(1, 32'h11, 0, 0, 0, 0, 0);
        applyStimulus(1, 32'h22, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        checkOutput("midReset_preCount", 64'(mCount[0]), 64'(3));
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        #2 reset_n = 1'b0;
        checkEn = 1'b0;
        #1 checkReset("midReset");
        modelReset();
        @(negedge clk);
        reset_n = 1'b1;
        checkEn = 1'b1;

        // Randomised traffic with only legal restore targets
        for (int c = 0; c < 3000; c++) begin
            pu = $urandom_range(0, 99) < 45;
            po = $urandom_range(0, 99) < 35;
            al = $urandom_range(0, 99) < 30;
            re = $urandom_range(0, 99) < 20;
            rs = 1'b0;
            id = 1'(0);
            if ($urandom_range(0, 99) < 12 && ckq.size() > 0) begin
                lo = re ? 1 : 0;
                if (lo < ckq.size()) begin
                    k  = int'($urandom_range(lo, ckq.size() - 1));
                    rs = 1'b1;
                    id = ckq[k].id;
                end
            end
            applyStimulus(pu, $urandom, po, al, re, rs, id);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
